time_set_ctrl: RTL and testbench

//  Button-driven time-setting controller sitting directly upstream of digital_clock.

---
 rtl/time_set_pkg.sv | 53 +++++
 rtl/time_set_ctrl_btn_press.sv | 66 ++++++
 rtl/time_set_ctrl.sv | 129 ++++++++++++
 tb/tb_time_set_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types, field limits and conversion helpers for the time-setting controller.
package time_set_pkg;

    typedef enum logic [2:0] {
        RUN,
        SET_HR,
        SET_MIN,
        SET_SEC,
        COMMIT
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HR   = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_SEC  = 2'd3
    } field_t;

    localparam int HR_MAX = 23;
    localparam int MS_MAX = 59;
    localparam int HR_W   = 5;
    localparam int MS_W   = 6;
    localparam int TIME_W = 17;

    // Two BCD digits to binary; anything non-BCD or above max_val becomes 0.
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens,
                                              input logic [3:0] ones,
                                              input int         max_val);
        logic [6:0] val;
        val = 7'(tens) * 7'd10 + 7'(ones);
        if (tens > 4'd9 || ones > 4'd9 || int'(val) > max_val)
            return 7'd0;
        return val;
    endfunction

    function automatic logic [6:0] step_wrap(input logic [6:0] val,
                                             input logic [6:0] max_val,
                                             input logic       up);
        if (up)
            return (val >= max_val) ? 7'd0 : val + 7'd1;
        return (val == 7'd0) ? max_val : val - 7'd1;
    endfunction

    function automatic field_t field_of(input state_t s);
        case (s)
            SET_HR:  return FIELD_HR;
            SET_MIN: return FIELD_MIN;
            SET_SEC: return FIELD_SEC;
            default: return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_press.sv
// Button press detector: registered rising-edge pulse; with SET_AUTOREPEAT_EN defined it
// also emits repeat pulses while the button is held and rpt_allow is high.
module btn_press
`ifdef SET_AUTOREPEAT_EN
#(
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
`ifdef SET_AUTOREPEAT_EN
    input  logic rpt_allow,
`endif
    output logic press
);

    logic btn_q;
    logic rpt_fire;

`ifdef SET_AUTOREPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             repeating;
    logic             holding;

    assign holding = rpt_allow && btn && btn_q;

    always_comb begin
        rpt_fire = 1'b0;
        if (holding)
            rpt_fire = repeating ? (hold_cnt == CNT_W'(REPEAT_PERIOD - 1))
                                 : (hold_cnt == CNT_W'(REPEAT_DELAY - 1));
    end

    // First repeat after REPEAT_DELAY held cycles, then one every REPEAT_PERIOD.
    always_ff @(posedge clk) begin
        if (rst || !holding) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (rpt_fire) begin
            hold_cnt  <= '0;
            repeating <= 1'b1;
        end else begin
            hold_cnt  <= hold_cnt + CNT_W'(1);
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
            press <= 1'b0;
        end else begin
            btn_q <= btn;
            press <= (btn & ~btn_q) | rpt_fire;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller feeding digital_clock (hours, minutes, seconds edit
// then commit strobe). Optional auto-repeat on inc/dec when SET_AUTOREPEAT_EN is defined.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int OW_CYCLES     = 2,
    parameter int TIMEOUT_CYC   = 30000000,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic [3:0]        hr_10s,
    input  logic [3:0]        hr_1s,
    input  logic [3:0]        min_10s,
    input  logic [3:0]        min_1s,
    input  logic [3:0]        sec_10s,
    input  logic [3:0]        sec_1s,
    output logic [TIME_W-1:0] time_in,
    output logic              time_ow,
    output logic              editing,
    output logic [1:0]        field_sel
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int OW_W = $clog2(OW_CYCLES + 1);

    state_t          state, next_state;
    logic [HR_W-1:0] edit_hr, hr_nxt;
    logic [MS_W-1:0] edit_min, min_nxt;
    logic [MS_W-1:0] edit_sec, sec_nxt;
    logic [TO_W-1:0] idle_cnt;
    logic [OW_W-1:0] ow_cnt;
    logic            mode_p, inc_p, dec_p;
    logic            step_up, step_dn, idle_clr, in_set;

`ifdef SET_AUTOREPEAT_EN
    logic rpt_allow;
    assign rpt_allow = in_set;

    btn_press #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_mode (
        .clk(clk), .rst(rst), .btn(btn_mode), .rpt_allow(1'b0), .press(mode_p));
    btn_press #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_inc (
        .clk(clk), .rst(rst), .btn(btn_inc), .rpt_allow(rpt_allow), .press(inc_p));
    btn_press #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dec (
        .clk(clk), .rst(rst), .btn(btn_dec), .rpt_allow(rpt_allow), .press(dec_p));
`else
    btn_press u_mode (.clk(clk), .rst(rst), .btn(btn_mode), .press(mode_p));
    btn_press u_inc  (.clk(clk), .rst(rst), .btn(btn_inc),  .press(inc_p));
    btn_press u_dec  (.clk(clk), .rst(rst), .btn(btn_dec),  .press(dec_p));
`endif

    assign in_set  = (state == SET_HR) || (state == SET_MIN) || (state == SET_SEC);
    assign step_up = inc_p & ~dec_p;
    assign step_dn = dec_p & ~inc_p;
    // The edit registers are the output register, so time_in never lags an edit.
    assign time_in = {edit_hr, edit_min, edit_sec};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state = state;
        hr_nxt     = edit_hr;
        min_nxt    = edit_min;
        sec_nxt    = edit_sec;
        idle_clr   = 1'b0;
        case (state)
            RUN: begin
                if (mode_p) begin
                    next_state = SET_HR;
                    idle_clr   = 1'b1;
                    hr_nxt     = HR_W'(bcd_to_bin(hr_10s, hr_1s, HR_MAX));
                    min_nxt    = MS_W'(bcd_to_bin(min_10s, min_1s, MS_MAX));
                    sec_nxt    = MS_W'(bcd_to_bin(sec_10s, sec_1s, MS_MAX));
                end
            end
            SET_HR, SET_MIN, SET_SEC: begin
                if (mode_p) begin
                    idle_clr   = 1'b1;
                    next_state = (state == SET_HR)  ? SET_MIN :
                                 (state == SET_MIN) ? SET_SEC : COMMIT;
                end else if (step_up || step_dn) begin
                    idle_clr = 1'b1;
                    if (state == SET_HR)
                        hr_nxt = HR_W'(step_wrap(7'(edit_hr), 7'(HR_MAX), step_up));
                    else if (state == SET_MIN)
                        min_nxt = MS_W'(step_wrap(7'(edit_min), 7'(MS_MAX), step_up));
                    else
                        sec_nxt = MS_W'(step_wrap(7'(edit_sec), 7'(MS_MAX), step_up));
                end else if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    next_state = RUN;
                end
            end
            COMMIT: begin
                if (ow_cnt == OW_W'(OW_CYCLES - 1))
                    next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments; reset is synchronous to clk.
        if (rst) begin
            state     <= RUN;
            edit_hr   <= '0;
            edit_min  <= '0;
            edit_sec  <= '0;
            idle_cnt  <= '0;
            ow_cnt    <= '0;
            time_ow   <= 1'b0;
            editing   <= 1'b0;
            field_sel <= FIELD_NONE;
        end else begin
            state     <= next_state;
            edit_hr   <= hr_nxt;
            edit_min  <= min_nxt;
            edit_sec  <= sec_nxt;
            idle_cnt  <= (idle_clr || !in_set) ? '0 : idle_cnt + TO_W'(1);
            ow_cnt    <= (state == COMMIT) ? ow_cnt + OW_W'(1) : '0;
            time_ow   <= (next_state == COMMIT);
            editing   <= (next_state != RUN);
            field_sel <= field_of(next_state);
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized bench for time_set_ctrl against an arithmetic reference model of the set flow.
// Expected results follow SET_AUTOREPEAT_EN when the macro is defined for the build.
module tb_time_set_ctrl;

    localparam int OW      = 2;
    localparam int TIMEOUT = 100;
    localparam int RDELAY  = 10;
    localparam int RPERIOD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_mode, btn_inc, btn_dec;
    logic [3:0]  hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s;
    logic [16:0] time_in;
    logic        time_ow, editing;
    logic [1:0]  field_sel;

    time_set_ctrl #(
        .OW_CYCLES(OW), .TIMEOUT_CYC(TIMEOUT), .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .hr_10s(hr_10s), .hr_1s(hr_1s), .min_10s(min_10s), .min_1s(min_1s),
        .sec_10s(sec_10s), .sec_1s(sec_1s),
        .time_in(time_in), .time_ow(time_ow), .editing(editing), .field_sel(field_sel)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 = running, 1/2/3 = editing hours/minutes/seconds.
    int m_mode = 0;
    int m_hr = 0, m_min = 0, m_sec = 0;
    int ign = 0;

    int          ow_seen = 0;
    logic [16:0] ow_time = '0;

    always @(negedge clk) begin
        if (time_ow === 1'b1) begin
            ow_seen++;
            ow_time = time_in;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd_val(input int t, input int o, input int maxv);
        if (t > 9 || o > 9 || t * 10 + o > maxv)
            return 0;
        return t * 10 + o;
    endfunction

    function automatic logic [31:0] m_time();
        return 32'({5'(m_hr), 6'(m_min), 6'(m_sec)});
    endfunction

    task automatic set_bcd(input int h, input int m, input int s);
        hr_10s  = 4'(h / 16); hr_1s  = 4'(h % 16);
        min_10s = 4'(m / 16); min_1s = 4'(m % 16);
        sec_10s = 4'(s / 16); sec_1s = 4'(s % 16);
    endtask

    task automatic model_apply(input bit m, input bit i, input bit d, output bit commit);
        int delta;
        commit = 1'b0;
        delta  = i ? 1 : -1;
        if (m) begin
            ign = 0;
            if (m_mode == 0) begin
                m_hr   = bcd_val(int'(hr_10s), int'(hr_1s), 23);
                m_min  = bcd_val(int'(min_10s), int'(min_1s), 59);
                m_sec  = bcd_val(int'(sec_10s), int'(sec_1s), 59);
                m_mode = 1;
            end else if (m_mode == 3) begin
                m_mode = 0;
                commit = 1'b1;
            end else begin
                m_mode++;
            end
        end else if (m_mode != 0 && (i ^ d)) begin
            ign = 0;
            if (m_mode == 1)      m_hr  = (m_hr  + 24 + delta) % 24;
            else if (m_mode == 2) m_min = (m_min + 60 + delta) % 60;
            else                  m_sec = (m_sec + 60 + delta) % 60;
        end else if (m_mode != 0) begin
            ign++;
        end
    endtask

    task automatic check_state(input string tag, input bit commit);
        check($sformatf("%s.time", tag), 32'(time_in), m_time());
        check($sformatf("%s.editing", tag), 32'(editing), 32'(m_mode != 0));
        check($sformatf("%s.field", tag), 32'(field_sel), 32'(m_mode));
        check($sformatf("%s.ow_len", tag), 32'(ow_seen), commit ? 32'(OW) : 32'd0);
        if (commit)
            check($sformatf("%s.ow_time", tag), 32'(ow_time), m_time());
    endtask

    task automatic op(input bit m, input bit i, input bit d, input string tag);
        bit commit;
        ow_seen = 0;
        @(negedge clk);
        btn_mode = m; btn_inc = i; btn_dec = d;
        repeat (2) @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (4) @(negedge clk);
        model_apply(m, i, d, commit);
        check_state(tag, commit);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_mode = 0; m_hr = 0; m_min = 0; m_sec = 0; ign = 0;
    endtask

    initial begin
        int hold_presses;
        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        set_bcd('h00, 'h00, 'h00);
        do_reset();
        ow_seen = 0;
        @(negedge clk);
        check_state("reset", 1'b0);
        check("reset.ow", 32'(time_ow), 32'd0);

        // Full set flow from 12:34:56.
        set_bcd('h12, 'h34, 'h56);
        op(1, 0, 0, "flow.mode1");
        op(0, 1, 0, "flow.inc1");
        op(0, 1, 0, "flow.inc2");
        op(1, 0, 0, "flow.mode2");
        op(0, 0, 1, "flow.dec");
        op(1, 0, 0, "flow.mode3");
        op(0, 1, 0, "flow.inc3");
        op(1, 0, 0, "flow.commit");
        check("flow.final", 32'(time_in), 32'({5'd14, 6'd33, 6'd57}));

        // Wrap at the field limits.
        set_bcd('h23, 'h10, 'h00);
        op(1, 0, 0, "wrap.enter");
        op(0, 1, 0, "wrap.hr_up");
        check("wrap.hr0", 32'(time_in[16:12]), 32'd0);
        op(0, 0, 1, "wrap.hr_dn");
        check("wrap.hr23", 32'(time_in[16:12]), 32'd23);
        op(1, 0, 0, "wrap.to_min");
        op(1, 0, 0, "wrap.to_sec");
        op(0, 0, 1, "wrap.sec_dn");
        check("wrap.sec59", 32'(time_in[5:0]), 32'd59);
        op(0, 1, 0, "wrap.sec_up");
        check("wrap.sec0", 32'(time_in[5:0]), 32'd0);
        op(1, 0, 0, "wrap.commit");

        // Invalid capture 27:61:5A, then simultaneous presses.
        set_bcd('h27, 'h61, 'h5A);
        op(1, 0, 0, "invalid.enter");
        check("invalid.zero", 32'(time_in), 32'd0);
        op(0, 1, 1, "simul.incdec");
        op(1, 1, 0, "simul.mode_inc");
        check("simul.hr_kept", 32'(time_in[16:12]), 32'd0);
        op(1, 0, 0, "simul.to_sec");
        op(1, 0, 0, "simul.commit");

        // Idle timeout while editing minutes.
        set_bcd('h08, 'h15, 'h30);
        op(1, 0, 0, "tmo.enter");
        op(1, 0, 0, "tmo.to_min");
        repeat (TIMEOUT - 10) @(negedge clk);
        check("tmo.still_edit", 32'(editing), 32'd1);
        repeat (10) @(negedge clk);
        m_mode = 0;
        ign = 0;
        check_state("tmo.after", 1'b0);

        // Reset while the commit strobe is high.
        set_bcd('h01, 'h02, 'h03);
        op(1, 0, 0, "rstc.enter");
        op(1, 0, 0, "rstc.min");
        op(1, 0, 0, "rstc.sec");
        @(negedge clk);
        btn_mode = 1'b1;
        repeat (2) @(negedge clk);
        check("rstc.ow_high", 32'(time_ow), 32'd1);
        btn_mode = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstc.ow_low", 32'(time_ow), 32'd0);
        check("rstc.editing", 32'(editing), 32'd0);
        check("rstc.time", 32'(time_in), 32'd0);
        m_mode = 0; m_hr = 0; m_min = 0; m_sec = 0; ign = 0;
        repeat (2) @(negedge clk);

        // Hold inc for 30 cycles in minutes starting from 0.
        set_bcd('h10, 'h00, 'h20);
        op(1, 0, 0, "hold.enter");
        op(1, 0, 0, "hold.to_min");
        ow_seen = 0;
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (30) @(negedge clk);
        btn_inc = 1'b0;
        repeat (4) @(negedge clk);
        hold_presses = 1;
`ifdef SET_AUTOREPEAT_EN
        for (int c = RDELAY; c < 30; c += RPERIOD)
            hold_presses++;
`endif
        m_min = (m_min + hold_presses) % 60;
        check_state("hold", 1'b0);
        op(1, 0, 0, "hold.to_sec");
        op(1, 0, 0, "hold.commit");

        // Randomized button sequences.
        for (int n = 0; n < 60; n++) begin
            int r;
            bit m, i, d;
            r = $urandom_range(0, 9);
            m = 1'b0; i = 1'b0; d = 1'b0;
            if (r <= 2)      m = 1'b1;
            else if (r <= 5) i = 1'b1;
            else if (r <= 7) d = 1'b1;
            else if (r == 8) begin i = 1'b1; d = (ign < 4); end
            else begin m = 1'b1; i = $urandom_range(0, 1) == 1; d = !i; end
            if (m && m_mode == 0) begin
                if ($urandom_range(0, 4) == 0)
                    set_bcd($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
                else
                    set_bcd($urandom_range(0, 2) * 16 + $urandom_range(0, 9),
                            $urandom_range(0, 6) * 16 + $urandom_range(0, 9),
                            $urandom_range(0, 6) * 16 + $urandom_range(0, 9));
            end
            op(m, i, d, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
